// File: rtl/pifo_sched_pkg.sv
// Shared scheduler definitions: default descriptor field positions, pause FSM
// states and the default-width rank/port types.
package pifo_sched_pkg;

  localparam int ROOT_RANK_START_DEF = 12;
  localparam int ROOT_RANK_END_DEF   = 29;
  localparam int ROOT_VALID_POS_DEF  = 31;
  localparam int RANK_W_DEF          = ROOT_RANK_END_DEF - ROOT_RANK_START_DEF + 1;
  localparam int PORT_W_DEF          = 2;
  localparam int TIMER_W_DEF         = 16;

  typedef enum logic {
    PAUSE_IDLE   = 1'b0,
    PAUSE_ACTIVE = 1'b1
  } pause_state_t;

  typedef logic [RANK_W_DEF-1:0] rank_t;
  typedef logic [PORT_W_DEF-1:0] port_t;

endpackage

// File: rtl/gpfc_pause_timer.sv
// Per-port GPFC pause: latches the pause rank and holds the port paused for
// exactly `quanta` cycles; a fresh update always reloads the timer.
module gpfc_pause_timer
  import pifo_sched_pkg::*;
#(
  parameter int RANK_W  = RANK_W_DEF,
  parameter int TIMER_W = TIMER_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd,
  input  logic [RANK_W-1:0]  upd_rank,
  input  logic [TIMER_W-1:0] upd_quanta,
  output logic               active,
  output logic [RANK_W-1:0]  rank
);

  pause_state_t       state;
  logic [TIMER_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PAUSE_IDLE;
      timer <= '0;
      rank  <= '0;
    end else if (upd) begin
      if (upd_quanta != '0) begin
        state <= PAUSE_ACTIVE;
        timer <= upd_quanta;
        rank  <= upd_rank;
      end else begin
        state <= PAUSE_IDLE;
        timer <= '0;
      end
    end else if (state == PAUSE_ACTIVE) begin
      // the cycle holding timer==1 is the last paused one
      if (timer == TIMER_W'(1)) begin
        state <= PAUSE_IDLE;
        timer <= '0;
      end else begin
        timer <= timer - TIMER_W'(1);
      end
    end
  end

  assign active = (state == PAUSE_ACTIVE);

endmodule

// File: rtl/pifo_multiport_bypass_checker.sv
// Multi-port root-PIFO bypass checker: per-port calendar-head compare gated by
// a timed GPFC pause, with one registered valid/ready output stage.
module pifo_multiport_bypass_checker
  import pifo_sched_pkg::*;
#(
  parameter int NUM_PORTS                = 4,
  parameter int PORT_W                   = PORT_W_DEF,
  parameter int PIFO_ROOT_WIDTH          = 32,
  parameter int PIFO_RANK_WIDTH          = RANK_W_DEF,
  parameter int ROOT_RANK_START_POS      = ROOT_RANK_START_DEF,
  parameter int ROOT_RANK_END_POS        = ROOT_RANK_END_DEF,
  parameter int ROOT_PIFO_INFO_VALID_POS = ROOT_VALID_POS_DEF,
  parameter int PAUSE_TIMER_W            = TIMER_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_axis_valid,
  output logic                                 s_axis_ready,
  input  logic [PIFO_ROOT_WIDTH-1:0]           s_axis_pifo_info,
  input  logic [PORT_W-1:0]                    s_axis_port,
  input  logic [NUM_PORTS*PIFO_ROOT_WIDTH-1:0] s_axis_calendar_top,
  input  logic                                 s_axis_gpfc_valid,
  input  logic [PORT_W-1:0]                    s_axis_gpfc_port,
  input  logic [PIFO_RANK_WIDTH-1:0]           s_axis_gpfc_pause_rank,
  input  logic [PAUSE_TIMER_W-1:0]             s_axis_gpfc_quanta,
  output logic                                 m_axis_valid,
  input  logic                                 m_axis_ready,
  output logic [PIFO_ROOT_WIDTH-1:0]           m_axis_pifo_info,
  output logic [PORT_W-1:0]                    m_axis_port,
  output logic                                 m_axis_bypass_en,
  output logic [NUM_PORTS-1:0]                 pause_active
);

  localparam int W = PIFO_ROOT_WIDTH;

  typedef struct packed {
    logic [W-1:0]      info;
    logic [PORT_W-1:0] port;
    logic              bypass;
  } dec_t;

  logic [NUM_PORTS-1:0]                      gpfc_hit;
  logic [NUM_PORTS-1:0]                      cand;
  logic [NUM_PORTS-1:0][PIFO_RANK_WIDTH-1:0] p_rank;
  logic [PIFO_RANK_WIDTH-1:0]                d_rank;
  logic                                      sel_cand;
  logic                                      accept;
  logic                                      unused_cal;
  dec_t                                      dec_d, dec_q;

  assign d_rank = s_axis_pifo_info[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
  // calendar heads only contribute their valid bit and rank field
  assign unused_cal = ^s_axis_calendar_top;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic                       top_vld;
    logic [PIFO_RANK_WIDTH-1:0] top_rank;
    logic                       paused;

    assign gpfc_hit[g] = s_axis_gpfc_valid & (s_axis_gpfc_port == PORT_W'(g));

    gpfc_pause_timer #(
      .RANK_W  (PIFO_RANK_WIDTH),
      .TIMER_W (PAUSE_TIMER_W)
    ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .upd        (gpfc_hit[g]),
      .upd_rank   (s_axis_gpfc_pause_rank),
      .upd_quanta (s_axis_gpfc_quanta),
      .active     (pause_active[g]),
      .rank       (p_rank[g])
    );

    assign top_vld  = s_axis_calendar_top[g*W + ROOT_PIFO_INFO_VALID_POS];
    assign top_rank = s_axis_calendar_top[g*W + ROOT_RANK_START_POS +: PIFO_RANK_WIDTH];
    assign paused   = pause_active[g] & (d_rank >= p_rank[g]);
    // equal ranks keep calendar order, so only strictly lower rank bypasses
    assign cand[g]  = ~paused & (~top_vld | (d_rank < top_rank));
  end

  // out-of-range ports match no lane and never bypass
  always_comb begin
    sel_cand = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (s_axis_port == PORT_W'(i)) sel_cand = cand[i];
  end

  assign dec_d.info   = s_axis_pifo_info;
  assign dec_d.port   = s_axis_port;
  assign dec_d.bypass = s_axis_pifo_info[ROOT_PIFO_INFO_VALID_POS] & sel_cand;

  assign s_axis_ready = ~rst & (~m_axis_valid | m_axis_ready);
  assign accept       = s_axis_valid & s_axis_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_valid <= 1'b0;
      dec_q        <= '0;
    end else if (accept) begin
      m_axis_valid <= 1'b1;
      dec_q        <= dec_d;
    end else if (m_axis_ready) begin
      m_axis_valid <= 1'b0;
    end
  end

  assign m_axis_pifo_info = dec_q.info;
  assign m_axis_port      = dec_q.port;
  assign m_axis_bypass_en = dec_q.bypass;

endmodule

// File: tb/tb_pifo_multiport_bypass_checker.sv
// Randomized + directed bench for pifo_multiport_bypass_checker against a
// cycle-level behavioural model (remaining-pause counters, stream register).
module tb_pifo_multiport_bypass_checker;

  localparam int NP = 4;
  localparam int PW = 3;

  logic          clk;
  logic          rst;
  logic          s_axis_valid;
  logic          s_axis_ready;
  logic [31:0]   s_axis_pifo_info;
  logic [PW-1:0] s_axis_port;
  logic [NP*32-1:0] s_axis_calendar_top;
  logic          s_axis_gpfc_valid;
  logic [PW-1:0] s_axis_gpfc_port;
  logic [17:0]   s_axis_gpfc_pause_rank;
  logic [15:0]   s_axis_gpfc_quanta;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic [31:0]   m_axis_pifo_info;
  logic [PW-1:0] m_axis_port;
  logic          m_axis_bypass_en;
  logic [NP-1:0] pause_active;

  pifo_multiport_bypass_checker #(.NUM_PORTS(NP), .PORT_W(PW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_pifo_info(s_axis_pifo_info), .s_axis_port(s_axis_port),
    .s_axis_calendar_top(s_axis_calendar_top),
    .s_axis_gpfc_valid(s_axis_gpfc_valid), .s_axis_gpfc_port(s_axis_gpfc_port),
    .s_axis_gpfc_pause_rank(s_axis_gpfc_pause_rank), .s_axis_gpfc_quanta(s_axis_gpfc_quanta),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_pifo_info(m_axis_pifo_info), .m_axis_port(m_axis_port),
    .m_axis_bypass_en(m_axis_bypass_en), .pause_active(pause_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic        e_valid;
  logic [31:0] e_info;
  logic [PW-1:0] e_port;
  logic        e_byp;
  int          rem [NP];
  int          prank [NP];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic v, input int r);
    logic [11:0] lo;
    lo = 12'($urandom);
    return {v, 1'b0, 18'(r), lo};
  endfunction

  function automatic logic model_byp(input logic [31:0] info, input int port);
    int r, tr;
    logic [31:0] top;
    logic paused;
    if (!info[31] || port >= NP) return 1'b0;
    r = int'(info[29:12]);
    top = s_axis_calendar_top[port*32 +: 32];
    tr = int'(top[29:12]);
    paused = (rem[port] > 0) && (r >= prank[port]);
    if (!top[31]) return !paused;
    return (r < tr) && !paused;
  endfunction

  // one clock: check ready before the edge, advance model, compare after it
  task automatic tick();
    logic exp_rdy, acc, byp;
    logic [NP-1:0] exp_pa;
    #1;
    exp_rdy = !rst && (!e_valid || m_axis_ready);
    chk("s_ready", s_axis_ready, exp_rdy);
    acc = s_axis_valid && exp_rdy;
    @(posedge clk);
    #1;
    byp = model_byp(s_axis_pifo_info, int'(s_axis_port));
    if (rst) begin
      e_valid = 0; e_info = '0; e_port = '0; e_byp = 0;
      for (int p = 0; p < NP; p++) begin rem[p] = 0; prank[p] = 0; end
    end else begin
      if (acc) begin
        e_valid = 1; e_info = s_axis_pifo_info; e_port = s_axis_port; e_byp = byp;
      end else if (m_axis_ready) e_valid = 0;
      for (int p = 0; p < NP; p++) begin
        if (s_axis_gpfc_valid && int'(s_axis_gpfc_port) == p) begin
          rem[p] = int'(s_axis_gpfc_quanta);
          if (s_axis_gpfc_quanta != 0) prank[p] = int'(s_axis_gpfc_pause_rank);
        end else if (rem[p] > 0) rem[p]--;
      end
    end
    for (int p = 0; p < NP; p++) exp_pa[p] = rem[p] > 0;
    chk("m_valid", m_axis_valid, e_valid);
    chk("m_info", m_axis_pifo_info, e_info);
    chk("m_port", m_axis_port, e_port);
    chk("m_bypass", m_axis_bypass_en, e_byp);
    chk("pause_active", pause_active, exp_pa);
  endtask

  task automatic desc(input int port, input int r);
    s_axis_valid = 1; s_axis_port = PW'(port); s_axis_pifo_info = mk(1'b1, r);
  endtask

  task automatic gpfc(input int port, input int r, input int q);
    s_axis_gpfc_valid = 1; s_axis_gpfc_port = PW'(port);
    s_axis_gpfc_pause_rank = 18'(r); s_axis_gpfc_quanta = 16'(q);
  endtask

  task automatic idle();
    s_axis_valid = 0; s_axis_gpfc_valid = 0;
  endtask

  initial begin
    e_valid = 0; e_info = '0; e_port = '0; e_byp = 0;
    for (int p = 0; p < NP; p++) begin rem[p] = 0; prank[p] = 0; end
    rst = 1; m_axis_ready = 1; s_axis_calendar_top = '0;
    s_axis_pifo_info = '0; s_axis_port = '0;
    s_axis_gpfc_port = '0; s_axis_gpfc_pause_rank = '0; s_axis_gpfc_quanta = '0;
    idle();
    tick(); tick();
    chk("rst_valid", m_axis_valid, 0);
    chk("rst_pause", pause_active, 0);
    rst = 0;

    // port 2 head rank 100
    s_axis_calendar_top[2*32 +: 32] = mk(1'b1, 100);
    desc(2, 50); tick();
    chk("tp_low_byp", m_axis_bypass_en, 1);
    desc(2, 100); tick();
    chk("tp_eq_byp", m_axis_bypass_en, 0);
    // port 1 head invalid, pause then partial pause
    s_axis_calendar_top[1*32 +: 32] = mk(1'b0, 7);
    desc(1, 500); tick();
    chk("tp_inv_byp", m_axis_bypass_en, 1);
    idle(); gpfc(1, 400, 10); tick();
    idle(); desc(1, 500); tick();
    chk("tp_paused_byp", m_axis_bypass_en, 0);
    desc(1, 300); tick();
    chk("tp_below_pause", m_axis_bypass_en, 1);
    idle();
    for (int i = 0; i < 10; i++) tick();

    // exact pause length, then early resume
    gpfc(0, 0, 5); tick(); idle();
    for (int i = 0; i < 7; i++) tick();
    gpfc(0, 0, 5); tick(); idle();
    tick();
    gpfc(0, 0, 0); tick(); idle();
    chk("resume", pause_active[0], 0);
    tick();

    // backpressure hold with changing head
    m_axis_ready = 0; desc(0, 10); s_axis_calendar_top[31:0] = mk(1'b1, 20); tick();
    for (int i = 0; i < 4; i++) begin
      desc(3, i); s_axis_calendar_top[31:0] = mk(1'b1, 5); tick();
    end
    chk("hold_byp", m_axis_bypass_en, 1);
    m_axis_ready = 1; idle(); tick(); tick();

    // back-to-back, then out-of-range port
    for (int p = 0; p < NP; p++) begin desc(p, $urandom_range(0, 200)); tick(); end
    desc(5, 1); tick();
    chk("port5_byp", m_axis_bypass_en, 0);

    // reset while an output is held and a pause is running
    gpfc(2, 0, 20); tick(); idle();
    m_axis_ready = 0; desc(1, 3); tick();
    rst = 1; tick();
    chk("rst_mid_valid", m_axis_valid, 0);
    tick();
    rst = 0; m_axis_ready = 1; idle(); tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      s_axis_valid = ($urandom_range(0, 3) != 0);
      s_axis_port = PW'($urandom_range(0, 5));
      s_axis_pifo_info = mk($urandom_range(0, 7) != 0, $urandom_range(0, 31));
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) == 0)
          s_axis_calendar_top[p*32 +: 32] = mk($urandom_range(0, 1) == 1, $urandom_range(0, 31));
      s_axis_gpfc_valid = ($urandom_range(0, 7) == 0);
      s_axis_gpfc_port = PW'($urandom_range(0, 5));
      s_axis_gpfc_pause_rank = 18'($urandom_range(0, 31));
      s_axis_gpfc_quanta = 16'($urandom_range(0, 8));
      m_axis_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
